softmax_bram_ctrl: RTL and testbench

- Core-side responder for the softmax external-access protocol: start/busy handshake, external write port A and external read port B.
- Owns the 1028-bit row buffer and sequences a run: streams input rows 0..11 to the softmax engine, then writes engine results to rows 12..23.
- Sits inside softmax_core between the host/bench interface and the approximation datapath.

---
 rtl/softmax_pkg.sv | 33 +++
 rtl/softmax_bram_ctrl_if.sv | 45 ++++
 rtl/softmax_row_ram.sv | 42 ++++
 rtl/softmax_bram_ctrl.sv | 126 ++++++++++++
 tb/tb_softmax_bram_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/softmax_pkg.sv
// Shared constants, row type and controller state encoding for the softmax row buffer.
package softmax_pkg;

    localparam int unsigned DATA_W   = 1028;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned N_ROWS   = 12;
    localparam int unsigned IN_BASE  = 0;
    localparam int unsigned OUT_BASE = 12;
    localparam int unsigned CNT_W    = 4;

    typedef logic [DATA_W-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_W1,
        RD_W2,
        SEND,
        COLLECT,
        DONE
    } ctrl_state_t;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Row/result counters stop at N_ROWS instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(N_ROWS)) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/softmax_bram_ctrl_if.sv
// Host/engine-facing signal bundle of softmax_bram_ctrl.
// o_err exists only when SOFTMAX_BRAM_CTRL_ERR_EN is defined.
interface softmax_bram_ctrl_if;
    import softmax_pkg::*;

    logic              i_en;
    logic              i_start;
    logic              o_busy;
    logic              i_ext_cena;
    logic              i_ext_wea;
    logic [ADDR_W-1:0] i_ext_addra;
    row_t              i_ext_dina;
    logic              i_ext_cenb;
    logic [ADDR_W-1:0] i_ext_addrb;
    row_t              o_ext_doutb;
    logic              o_eng_valid;
    row_t              o_eng_data;
    logic              o_eng_last;
    logic              i_eng_ready;
    logic              i_res_valid;
    row_t              i_res_data;
    logic              o_res_ready;
`ifdef SOFTMAX_BRAM_CTRL_ERR_EN
    logic              o_err;
`endif

    modport master (
        output i_en, i_start, i_ext_cena, i_ext_wea, i_ext_addra, i_ext_dina,
               i_ext_cenb, i_ext_addrb, i_eng_ready, i_res_valid, i_res_data,
        input  o_busy, o_ext_doutb, o_eng_valid, o_eng_data, o_eng_last, o_res_ready
`ifdef SOFTMAX_BRAM_CTRL_ERR_EN
        , input o_err
`endif
    );

    modport slave (
        input  i_en, i_start, i_ext_cena, i_ext_wea, i_ext_addra, i_ext_dina,
               i_ext_cenb, i_ext_addrb, i_eng_ready, i_res_valid, i_res_data,
        output o_busy, o_ext_doutb, o_eng_valid, o_eng_data, o_eng_last, o_res_ready
`ifdef SOFTMAX_BRAM_CTRL_ERR_EN
        , output o_err
`endif
    );

endinterface

// File: rtl/softmax_row_ram.sv
// DEPTH x DATA_W row buffer: one write port, one read port with address and data registers.
module softmax_row_ram
    import softmax_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  row_t              i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output row_t              o_rdata
);

    row_t              mem [DEPTH];
    logic [ADDR_W-1:0] raddr_q;
    logic              re_q;
    row_t              rdata_q;

    // Contents survive reset; only the read pipeline is cleared.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_en && i_we && addr_ok(i_waddr)) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            raddr_q <= '0;
            re_q    <= 1'b0;
            rdata_q <= '0;
        end else if (i_en) begin
            re_q <= i_re;
            if (i_re) raddr_q <= i_raddr;
            if (re_q) rdata_q <= addr_ok(raddr_q) ? mem[raddr_q] : '0;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/softmax_bram_ctrl.sv
// Row buffer controller: external ports A/B while idle, streams rows 0..11 to the engine
// and stores results to rows 12..23. Optional sticky o_err via SOFTMAX_BRAM_CTRL_ERR_EN.
module softmax_bram_ctrl
    import softmax_pkg::*;
(
    input logic                i_clk,
    input logic                i_rst_n,
    softmax_bram_ctrl_if.slave bus
);

    ctrl_state_t       state_q, state_d;
    logic              start_q;
    logic [CNT_W-1:0]  row_q, row_d, res_q, res_d;
    row_t              eng_data_q, doutb_q;
    logic              ext_rd1_q, ext_rd2_q;

    logic              busy, start_edge, ext_rd, res_fire;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    row_t              ram_wdata, ram_rdata;

    assign busy       = (state_q != IDLE);
    assign start_edge = bus.i_start & ~start_q;
    assign ext_rd     = ~busy & bus.i_ext_cenb;
    assign res_fire   = busy & bus.i_res_valid & (res_q < CNT_W'(N_ROWS));

    // Port A is owned by the result path for the whole run.
    assign ram_we    = busy ? res_fire : (bus.i_ext_cena & bus.i_ext_wea);
    assign ram_waddr = busy ? ADDR_W'(OUT_BASE + 32'(res_q)) : bus.i_ext_addra;
    assign ram_wdata = busy ? bus.i_res_data : bus.i_ext_dina;
    assign ram_re    = (state_q == RD_ADDR) | ext_rd;
    assign ram_raddr = busy ? ADDR_W'(IN_BASE + 32'(row_q)) : bus.i_ext_addrb;

    softmax_row_ram u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (bus.i_en),
        .i_we    (ram_we),
        .i_waddr (ram_waddr),
        .i_wdata (ram_wdata),
        .i_re    (ram_re),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = RD_ADDR;
                    row_d   = '0;
                    res_d   = '0;
                end
            end
            RD_ADDR: state_d = RD_W1;
            RD_W1:   state_d = RD_W2;
            RD_W2:   state_d = SEND;
            SEND: begin
                if (bus.i_eng_ready) begin
                    row_d   = sat_inc(row_q);
                    state_d = (row_q == CNT_W'(N_ROWS - 1)) ? COLLECT : RD_ADDR;
                end
            end
            COLLECT: begin
                // Results may all have arrived while rows were still being sent.
                if ((res_q == CNT_W'(N_ROWS)) ||
                    (res_fire && (res_q == CNT_W'(N_ROWS - 1)))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (res_fire) res_d = sat_inc(res_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            row_q      <= '0;
            res_q      <= '0;
            eng_data_q <= '0;
            doutb_q    <= '0;
            ext_rd1_q  <= 1'b0;
            ext_rd2_q  <= 1'b0;
        end else if (bus.i_en) begin
            state_q   <= state_d;
            start_q   <= bus.i_start;
            row_q     <= row_d;
            res_q     <= res_d;
            ext_rd1_q <= ext_rd;
            ext_rd2_q <= ext_rd1_q;
            if (ext_rd2_q)         doutb_q    <= ram_rdata;
            if (state_q == RD_W2)  eng_data_q <= ram_rdata;
        end
    end

    assign bus.o_busy      = busy;
    assign bus.o_ext_doutb = doutb_q;
    assign bus.o_eng_valid = (state_q == SEND);
    assign bus.o_eng_data  = eng_data_q;
    assign bus.o_eng_last  = (state_q == SEND) && (row_q == CNT_W'(N_ROWS - 1));
    assign bus.o_res_ready = busy;

`ifdef SOFTMAX_BRAM_CTRL_ERR_EN
    logic err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (bus.i_en) begin
            if ((busy && ((bus.i_ext_cena & bus.i_ext_wea) | bus.i_ext_cenb | start_edge)) ||
                (!busy && bus.i_res_valid)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.o_err = err_q;
`endif

endmodule

// File: tb/tb_softmax_bram_ctrl.sv
// Scoreboard bench for softmax_bram_ctrl: port A/B access, engine streaming, results, mid-run reset.
module tb_softmax_bram_ctrl;
    import softmax_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    row_t eng_q[$];
    row_t rd_q[$];
    row_t dout_model = '0;

    always #5 clk = ~clk;

    softmax_bram_ctrl_if bus ();

    softmax_bram_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input row_t obs, input row_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (low 96 bits)", tag, obs[95:0], exp[95:0]);
        end
    endtask

    function automatic row_t pat(input int v);
        row_t r;
        for (int b = 0; b < int'(DATA_W); b++) r[b] = v[b % 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_write(input int a, input row_t d);
        bus.i_ext_cena  = 1'b1;
        bus.i_ext_wea   = 1'b1;
        bus.i_ext_addra = ADDR_W'(a);
        bus.i_ext_dina  = d;
        tick();
        bus.i_ext_cena  = 1'b0;
        bus.i_ext_wea   = 1'b0;
    endtask

    task automatic ext_read(input int a, input row_t exp);
        rd_q.push_back(exp);
        bus.i_ext_cenb  = 1'b1;
        bus.i_ext_addrb = ADDR_W'(a);
        tick();
        bus.i_ext_cenb  = 1'b0;
        check_eq("doutb_hold_n", bus.o_ext_doutb, dout_model);
        tick();
        check_eq("doutb_hold_n1", bus.o_ext_doutb, dout_model);
        tick();
        dout_model = rd_q.pop_front();
        check_eq("doutb_n2", bus.o_ext_doutb, dout_model);
    endtask

    task automatic start_run();
        for (int i = 0; i < int'(N_ROWS); i++) eng_q.push_back(pat(int'(IN_BASE) + i));
        bus.i_start = 1'b1;
        check_eq("busy_pre_start", row_t'(bus.o_busy), row_t'(0));
        tick();
        check_eq("busy_after_edge", row_t'(bus.o_busy), row_t'(1));
        tick();
        bus.i_start = 1'b0;
    endtask

    // Engine model: holds ready low for 'stall' sampled cycles per row, then accepts it.
    task automatic engine(input int stall, input int max_rows, input bit inject);
        int sent  = 0;
        int waits = 0;
        int cyc   = 0;
        while (sent < max_rows && cyc < 2000) begin
            if (inject && cyc == 5) begin
                bus.i_ext_cena  = 1'b1;
                bus.i_ext_wea   = 1'b1;
                bus.i_ext_addra = ADDR_W'(3);
                bus.i_ext_dina  = pat(8'h77);
                bus.i_ext_cenb  = 1'b1;
                bus.i_ext_addrb = ADDR_W'(3);
                bus.i_start     = 1'b1;
            end else if (inject && cyc == 6) begin
                bus.i_ext_cena  = 1'b0;
                bus.i_ext_wea   = 1'b0;
                bus.i_ext_cenb  = 1'b0;
                bus.i_start     = 1'b0;
            end
            if (bus.o_eng_valid && eng_q.size() == 0) begin
                check_eq("eng_extra_row", row_t'(bus.o_eng_valid), row_t'(0));
                bus.i_eng_ready = 1'b1;
            end else if (bus.o_eng_valid && waits < stall) begin
                check_eq("eng_stall_stable", bus.o_eng_data, eng_q[0]);
                bus.i_eng_ready = 1'b0;
                waits++;
            end else if (bus.o_eng_valid) begin
                check_eq("eng_data", bus.o_eng_data, eng_q.pop_front());
                check_eq("eng_last", row_t'(bus.o_eng_last),
                         row_t'(sent == int'(N_ROWS) - 1));
                bus.i_eng_ready = 1'b1;
                sent++;
                waits = 0;
            end else begin
                bus.i_eng_ready = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.i_eng_ready = 1'b0;
        check_eq("eng_rows_in_budget", row_t'(sent), row_t'(max_rows));
    endtask

    task automatic send_results(input int base);
        check_eq("eng_valid_after_last", row_t'(bus.o_eng_valid), row_t'(0));
        for (int j = 0; j < int'(N_ROWS); j++) begin
            bus.i_res_valid = 1'b1;
            bus.i_res_data  = pat(base + j);
            check_eq("res_ready", row_t'(bus.o_res_ready), row_t'(1));
            tick();
        end
        bus.i_res_valid = 1'b0;
        check_eq("busy_in_done", row_t'(bus.o_busy), row_t'(1));
        tick();
        check_eq("busy_fall", row_t'(bus.o_busy), row_t'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        bus.i_en        = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_ext_cena  = 1'b0;
        bus.i_ext_wea   = 1'b0;
        bus.i_ext_addra = '0;
        bus.i_ext_dina  = '0;
        bus.i_ext_cenb  = 1'b0;
        bus.i_ext_addrb = '0;
        bus.i_eng_ready = 1'b0;
        bus.i_res_valid = 1'b0;
        bus.i_res_data  = '0;
        tick();
        tick();
        check_eq("rst_busy", row_t'(bus.o_busy), row_t'(0));
        check_eq("rst_eng_valid", row_t'(bus.o_eng_valid), row_t'(0));
        check_eq("rst_eng_last", row_t'(bus.o_eng_last), row_t'(0));
        check_eq("rst_res_ready", row_t'(bus.o_res_ready), row_t'(0));
        check_eq("rst_doutb", bus.o_ext_doutb, row_t'(0));
`ifdef SOFTMAX_BRAM_CTRL_ERR_EN
        check_eq("rst_err", row_t'(bus.o_err), row_t'(0));
`endif
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < int'(N_ROWS); i++) ext_write(i, pat(i));
        ext_read(5, pat(5));
        ext_read(0, pat(0));

        // Run 1: 2-cycle start pulse, engine always ready.
        start_run();
        engine(0, int'(N_ROWS), 1'b0);
        send_results(8'hA0);
        for (int j = 0; j < int'(N_ROWS); j++) ext_read(int'(OUT_BASE) + j, pat(8'hA0 + j));

        // Clock enable low freezes the read pipeline.
        bus.i_en        = 1'b0;
        bus.i_ext_cenb  = 1'b1;
        bus.i_ext_addrb = ADDR_W'(7);
        tick();
        tick();
        tick();
        bus.i_ext_cenb = 1'b0;
        check_eq("en_low_doutb_hold", bus.o_ext_doutb, dout_model);
        bus.i_en = 1'b1;
        tick();
        tick();
        check_eq("en_low_no_read", bus.o_ext_doutb, dout_model);

        // Run 2: stalling engine, illegal port A/B access and start edge while busy.
        start_run();
        engine(3, int'(N_ROWS), 1'b1);
        check_eq("doutb_hold_busy", bus.o_ext_doutb, dout_model);
        send_results(8'hB0);
`ifdef SOFTMAX_BRAM_CTRL_ERR_EN
        check_eq("err_sticky", row_t'(bus.o_err), row_t'(1));
`endif
        tick();
        tick();
        tick();
        tick();
        check_eq("no_second_run", row_t'(bus.o_busy), row_t'(0));
        ext_read(3, pat(3));
        ext_read(int'(OUT_BASE), pat(8'hB0));
        ext_read(int'(OUT_BASE) + int'(N_ROWS) - 1, pat(8'hBB));

        // Run 3: reset after 6 rows, then a fresh full run.
        start_run();
        engine(0, 6, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dout_model = '0;
        check_eq("midrst_busy", row_t'(bus.o_busy), row_t'(0));
        check_eq("midrst_eng_valid", row_t'(bus.o_eng_valid), row_t'(0));
        check_eq("midrst_res_ready", row_t'(bus.o_res_ready), row_t'(0));
        check_eq("midrst_doutb", bus.o_ext_doutb, row_t'(0));
        eng_q.delete();
        tick();
        start_run();
        engine(1, int'(N_ROWS), 1'b0);
        send_results(8'hC0);
        ext_read(int'(OUT_BASE) + 4, pat(8'hC4));
        ext_read(int'(OUT_BASE) + int'(N_ROWS) - 1, pat(8'hCB));
        ext_read(1, pat(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
